// File: rtl/div_seq_32_pkg.sv
// div_seq_32_pkg: shared width and FSM state encodings for the sequential divider
package div_seq_32_pkg;
  localparam int W = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/add_32.sv
// add_32: adder/subtractor; sub_in=1 gives a-b with carry=1 meaning no borrow
module add_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub_in,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         overflow
);
  logic [W-1:0] bx;
  assign bx = b ^ {W{sub_in}};
  assign {carry, sum} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub_in};
  assign overflow = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/div_seq_32.sv
// div_seq_32: unsigned restoring divider, one quotient bit per RUN cycle
module div_seq_32
  import div_seq_32_pkg::*;
#(
  parameter int w = W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [w-1:0] dividend,
  input  logic [w-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [w-1:0] quotient,
  output logic [w-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = $clog2(w + 1);
  state_e state_q, state_d;
  logic [w-1:0] r_q, q_q, d_q, quo_q, rem_q;
  logic [w-1:0] r_sh, q_sh, r_nx, trial;
  logic [CW-1:0] cnt_q;
  logic dbz_q, carry, acc, last, unused_ovf;
  // The bit shifted out of R means the shifted value is >= 2^w, so the step is always accepted.
  assign r_sh = {r_q[w-2:0], q_q[w-1]};
  assign acc  = r_q[w-1] | carry;
  assign q_sh = {q_q[w-2:0], acc};
  assign r_nx = acc ? trial : r_sh;
  assign last = cnt_q == CW'(w - 1);
  add_32 #(.W(w)) u_sub (
    .a(r_sh),
    .b(d_q),
    .sub_in(1'b1),
    .sum(trial),
    .carry(carry),
    .overflow(unused_ovf)
  );
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Next state: zero divisor skips RUN; DONE always returns to IDLE
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? ((divisor == '0) ? DONE : RUN) : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  // Status outputs decoded from state
  always_comb begin
    busy = state_q != IDLE;
    done = state_q == DONE;
  end
  // Datapath; visible results change only on entry to DONE so they stay stable while busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      r_q   <= '0;
      q_q   <= dividend;
      d_q   <= divisor;
      cnt_q <= '0;
      if (divisor == '0) begin
        quo_q <= '1;
        rem_q <= dividend;
        dbz_q <= 1'b1;
      end
    end else if (state_q == RUN) begin
      r_q   <= r_nx;
      q_q   <= q_sh;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        quo_q <= q_sh;
        rem_q <= r_nx;
        dbz_q <= 1'b0;
      end
    end
  end
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: directed scoreboard bench for the sequential divider
module tb_div_seq_32;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic prev_z = 1'b0;
  div_seq_32 dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // Drive start for one cycle (cycle 0) and push the expected result
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = W + 1;
    end
    sb.push_back(e);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  // Wait for done from cycle 1 onward; optionally inject starts in cycle 5 and cycle w+1
  task automatic wait_done(input string tag, input bit inj);
    exp_t e;
    int c;
    bit seen;
    c = 1;
    seen = 1'b0;
    e = sb.pop_front();
    while (c <= W + 8 && !seen) begin
      start = inj && (c == 5 || c == W + 1);
      if (start) begin
        dividend = 32'd55;
        divisor = 32'd3;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_hold_q"}, quotient, prev_q);
        chk({tag, "_hold_r"}, remainder, prev_r);
        chk({tag, "_hold_z"}, {31'd0, div_by_zero}, {31'd0, prev_z});
        @(posedge clk); #1;
        c++;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, c, e.lat);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    chk({tag, "_quotient"}, quotient, e.q);
    chk({tag, "_remainder"}, remainder, e.r);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.z});
    prev_q = e.q;
    prev_r = e.r;
    prev_z = e.z;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_keep_q"}, quotient, e.q);
    chk({tag, "_keep_r"}, remainder, e.r);
    @(posedge clk); #1;
  endtask
  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_z", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(32'd100, 32'd7);               wait_done("d100_7", 1'b0);
    start_op(32'hFFFFFFFF, 32'h80000000);   wait_done("dmax_msb", 1'b0);
    start_op(32'hFFFFFFFF, 32'd1);          wait_done("dmax_1", 1'b0);
    start_op(32'd5, 32'd7);                 wait_done("d5_7", 1'b0);
    start_op(32'd0, 32'd3);                 wait_done("d0_3", 1'b0);
    start_op(32'h1234, 32'd0);              wait_done("dzero", 1'b0);
    start_op(32'd100, 32'd7);               wait_done("d100_7_inj", 1'b1);
    start_op(32'd20, 32'd6);                wait_done("d20_6", 1'b0);
    start_op(32'hDEADBEEF, 32'h00012345);   wait_done("dbeef", 1'b0);
    // Abort a run with reset in cycle 10
    start_op(32'd100, 32'd7);
    void'(sb.pop_front());
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_q", quotient, 32'd0);
    chk("abort_r", remainder, 32'd0);
    chk("abort_z", {31'd0, div_by_zero}, 32'd0);
    pulses = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 32'd0);
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    @(posedge clk); #1;
    start_op(32'd9, 32'd2);                 wait_done("d9_2", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
